// File: rtl/detector_borda_pkg.sv
// Shared constants for the edge detector: channel mode encoding and widths.
package detector_borda_pkg;

    localparam int MODO_W = 2;
    localparam int CNT_W  = 8;

    typedef enum logic [MODO_W-1:0] {
        MODO_OFF     = 2'b00,
        MODO_SUBIDA  = 2'b01,
        MODO_DESCIDA = 2'b10,
        MODO_AMBAS   = 2'b11
    } modo_e;

endpackage

// File: rtl/detector_borda_if.sv
// Channel bus of the edge detector: levels/modes/clears in, pulses/flags/irq out.
interface detector_borda_if #(
    parameter int N = 8
);
    logic [N-1:0]   entrada;
    logic [2*N-1:0] modo;
    logic [N-1:0]   clr;
    logic [N-1:0]   pulso;
    logic [N-1:0]   sticky;
    logic [N-1:0]   ovf;
    logic           irq;

    modport master (
        output entrada, modo, clr,
        input  pulso, sticky, ovf, irq
    );

    modport slave (
        input  entrada, modo, clr,
        output pulso, sticky, ovf, irq
    );
endinterface

// File: rtl/detector_borda_canal.sv
// One detector channel: synchronizer, optional debounce, edge qualify, sticky/ovf.
// Debounce filter is compiled in only when DETECTOR_BORDA_DEBOUNCE_EN is defined.
module detector_borda_canal
    import detector_borda_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entrada,
    input  logic [MODO_W-1:0] modo,
    input  logic              clr,
    output logic              pulso,
    output logic              sticky,
    output logic              ovf
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("DEB_CYCLES must be 1..255");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   lvl;
    logic                   lvl_q;
    logic                   evento;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], entrada};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef DETECTOR_BORDA_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             f;
    logic [CNT_W-1:0] cnt;

    // f flips on the DEB_CYCLES-th consecutive mismatching sample; any match restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            f   <= 1'b0;
            cnt <= '0;
        end else if (s == f) begin
            cnt <= '0;
        end else if (cnt == DEB_LAST) begin
            f   <= ~f;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = f;
`else
    assign lvl = s;
`endif

    // lvl_q is the level the edge stage last saw; without debounce it is the filtered level itself.
    // NOTE: evento gets a default before the case so no latch is inferred.
    always_comb begin
        evento = 1'b0;
        case (modo_e'(modo))
            MODO_OFF:     evento = 1'b0;
            MODO_SUBIDA:  evento = lvl & ~lvl_q;
            MODO_DESCIDA: evento = ~lvl & lvl_q;
            MODO_AMBAS:   evento = lvl ^ lvl_q;
            default:      evento = 1'b0;
        endcase
    end

    // A same-cycle event beats clr for sticky; clr still wins for ovf.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q  <= 1'b0;
            pulso  <= 1'b0;
            sticky <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            lvl_q <= lvl;
            pulso <= evento;
            if (clr) begin
                sticky <= evento;
                ovf    <= 1'b0;
            end else if (evento) begin
                sticky <= 1'b1;
                if (sticky) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/detector_borda_cfg.sv
// N-channel edge detector with sticky flags and a registered summary interrupt.
// Define DETECTOR_BORDA_DEBOUNCE_EN to compile in the per-channel debounce filter.
module detector_borda_cfg
    import detector_borda_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    detector_borda_if.slave  bus
);

    if (N < 1 || N > 32) begin : g_bad_n
        $error("N must be 1..32");
    end

    logic [N-1:0] pulso;
    logic [N-1:0] sticky;
    logic [N-1:0] ovf;
    logic         irq;

    for (genvar i = 0; i < N; i++) begin : g_canal
        detector_borda_canal #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_canal (
            .clk     (clk),
            .rst     (rst),
            .entrada (bus.entrada[i]),
            .modo    (bus.modo[MODO_W*i +: MODO_W]),
            .clr     (bus.clr[i]),
            .pulso   (pulso[i]),
            .sticky  (sticky[i]),
            .ovf     (ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |sticky;
        end
    end

    assign bus.pulso  = pulso;
    assign bus.sticky = sticky;
    assign bus.ovf    = ovf;
    assign bus.irq    = irq;

endmodule

// File: tb/tb_detector_borda_cfg.sv
// Directed bench for detector_borda_cfg; expected latency follows DETECTOR_BORDA_DEBOUNCE_EN.
module tb_detector_borda_cfg;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef DETECTOR_BORDA_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
    localparam int LAT    = SYNC + DEB + 1;
`else
    localparam bit DEB_ON = 1'b0;
    localparam int LAT    = SYNC + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    detector_borda_if #(.N(N)) bus ();

    detector_borda_cfg #(
        .N           (N),
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks the whole pulso vector each cycle: vec at cycles at1/at2, zero otherwise.
    task automatic watch(input string tag, input int cycles, input int at1, input int at2,
                         input logic [N-1:0] vec);
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            check($sformatf("%s_pulso@%0d", tag, k), bus.pulso,
                  (k == at1 || k == at2) ? vec : '0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.entrada = '0;
        bus.modo    = 16'h5555;
        bus.clr     = '0;
        tick(3);
        check("rst_pulso", bus.pulso, 0);
        check("rst_sticky", bus.sticky, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_irq", bus.irq, 0);
        rst = 1'b0;

        // Single rising event on channel 0 and the irq that follows it.
        bus.entrada[0] = 1'b1;
        watch("ch0_rise", LAT, LAT, -1, 8'h01);
        check("ch0_sticky", bus.sticky, 8'h01);
        check("ch0_irq_early", bus.irq, 0);
        tick(1);
        check("ch0_irq", bus.irq, 1);
        check("ch0_pulso_once", bus.pulso, 0);

        // Both-edge mode: two events, the second one overflows.
        bus.modo[3:2]  = 2'b11;
        bus.entrada[1] = 1'b1;
        watch("ch1_rise", 20, LAT, -1, 8'h02);
        check("ch1_ovf_first", bus.ovf, 0);
        bus.entrada[1] = 1'b0;
        watch("ch1_fall", LAT + 1, LAT, -1, 8'h02);
        check("ch1_sticky", bus.sticky, 8'h03);
        check("ch1_ovf", bus.ovf, 8'h02);

        // Three-cycle glitch: filtered out only when debounce is compiled in.
        bus.entrada[2] = 1'b1;
        watch("ch2_glitch_hi", 3, DEB_ON ? -1 : 3, -1, 8'h04);
        bus.entrada[2] = 1'b0;
        watch("ch2_glitch_lo", LAT + 3, -1, -1, 8'h00);
        check("ch2_sticky", bus.sticky[2], DEB_ON ? 0 : 1);

        // Mode off keeps tracking; a later mode change alone makes no pulse.
        bus.modo[7:6]  = 2'b00;
        bus.entrada[3] = 1'b1;
        watch("ch3_off", LAT + 2, -1, -1, 8'h00);
        check("ch3_off_sticky", bus.sticky[3], 0);
        bus.modo[7:6] = 2'b01;
        bus.modo[3:2] = 2'b10;
        watch("modo_chg", 4, -1, -1, 8'h00);
        bus.modo[7:6]  = 2'b10;
        bus.entrada[3] = 1'b0;
        watch("ch3_fall", LAT + 1, LAT, -1, 8'h08);

        // Clear everything; irq drops one cycle after sticky.
        bus.clr = '1;
        tick(1);
        bus.clr = '0;
        check("clr_all_sticky", bus.sticky, 0);
        check("clr_all_ovf", bus.ovf, 0);
        check("clr_all_irq_lag", bus.irq, 1);
        tick(1);
        check("clr_all_irq", bus.irq, 0);

        // Channel 0: set sticky, then clr coincident with a new event.
        bus.entrada[0] = 1'b0;
        watch("ch0_fall_off", LAT + 2, -1, -1, 8'h00);
        bus.entrada[0] = 1'b1;
        watch("ch0_rise2", LAT, LAT, -1, 8'h01);
        check("ch0_sticky2", bus.sticky[0], 1);
        bus.entrada[0] = 1'b0;
        watch("ch0_fall_off2", LAT + 2, -1, -1, 8'h00);
        bus.entrada[0] = 1'b1;
        tick(LAT - 1);
        bus.clr[0] = 1'b1;
        tick(1);
        bus.clr[0] = 1'b0;
        check("clr_evt_pulso", bus.pulso, 8'h01);
        check("clr_evt_sticky", bus.sticky[0], 1);
        check("clr_evt_ovf", bus.ovf[0], 0);
        bus.clr[0] = 1'b1;
        tick(1);
        bus.clr[0] = 1'b0;
        check("clr_only_sticky", bus.sticky, 0);
        tick(1);
        check("clr_only_irq", bus.irq, 0);

        // All channels high through reset release.
        rst         = 1'b1;
        bus.entrada = '1;
        bus.modo    = 16'h5555;
        tick(3);
        check("rst2_pulso", bus.pulso, 0);
        check("rst2_sticky", bus.sticky, 0);
        rst = 1'b0;
        watch("rst_rel", LAT + 3, LAT, -1, 8'hFF);
        check("rst_rel_sticky", bus.sticky, 8'hFF);

        // Reset while the falling edges are still in flight.
        bus.modo    = 16'hFFFF;
        bus.entrada = '0;
        tick(LAT - 2);
        rst = 1'b1;
        watch("rst_mid", 2, -1, -1, 8'h00);
        rst = 1'b0;
        watch("rst_mid_post", LAT + 3, -1, -1, 8'h00);
        check("rst_mid_sticky", bus.sticky, 0);
        check("rst_mid_irq", bus.irq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/detector_borda_cfg.md
DETECTOR_BORDA_CFG -- requirements
Module: detector_borda_cfg

Interface
REQ-001 SHALL have parameter N, default 8: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel (2..4).
REQ-003 SHALL have parameter DEB_CYCLES, default 4: consecutive stable samples required by the debounce filter (1..255).
REQ-004 SHALL have port clk  input  1: sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port entrada  input  N: asynchronous channel levels.
REQ-007 SHALL have port modo  input  2*N: per-channel mode, bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port clr  input  N: write-1-to-clear of sticky/ovf per channel.
REQ-009 SHALL have port pulso  output  N: registered one-cycle event pulse per channel.
REQ-010 SHALL have port sticky  output  N: latched event flag per channel.
REQ-011 SHALL have port ovf  output  N: event occurred while sticky already set.
REQ-012 SHALL have port irq  output  1: OR of all sticky bits, registered.

Function
REQ-013 Each channel SHALL pass entrada[i] through SYNC_STAGES flops to give level s[i].
REQ-014 Filtered level f[i] SHALL toggle when s[i] differs from f[i] for DEB_CYCLES consecutive cycles; per-channel counter SHALL clear whenever s[i] equals f[i].
REQ-015 Qualifying event: f[i] 0->1 with mode 01/11, or f[i] 1->0 with mode 10/11; mode 00 SHALL produce no events while f[i] keeps tracking.
REQ-016 pulso[i] SHALL be high exactly one cycle per qualifying event, in the cycle after f[i] changes; total latency entrada->pulso = SYNC_STAGES+DEB_CYCLES+1 cycles (debounce compiled in).
REQ-017 Glitches shorter than DEB_CYCLES cycles at s[i] SHALL produce no f[i] change and no pulse.
REQ-018 sticky[i] SHALL set in the same cycle pulso[i] rises and hold until cleared.
REQ-019 ovf[i] SHALL set on a qualifying event when sticky[i] is already 1 and clr[i] is 0.
REQ-020 clr[i]=1 SHALL clear sticky[i] and ovf[i] next cycle; simultaneous clr[i] and event: sticky[i] set, ovf[i] cleared (event wins).
REQ-021 modo changes SHALL take effect on the next f[i] comparison; no pulse generated by a mode change alone.
REQ-022 irq SHALL equal OR of sticky, one cycle later than sticky.

Reset
REQ-023 rst SHALL zero synchronizer flops, f, debounce counters, pulso, sticky, ovf, irq on the next clock edge.
REQ-024 A channel held high through reset release SHALL produce a rising event after full latency (f starts at 0).
REQ-025 rst asserted mid-debounce or mid-pulse SHALL discard the pending event with no pulse.

Configuration
REQ-026 Macro DETECTOR_BORDA_DEBOUNCE_EN defined: debounce filter per REQ-014/017 compiled in.
REQ-027 Macro undefined: f[i] SHALL be s[i] registered once, no counters, latency SYNC_STAGES+1, DEB_CYCLES ignored.

Structure
REQ-028 Package detector_borda_pkg SHALL hold the mode constants MODO_OFF/MODO_SUBIDA/MODO_DESCIDA/MODO_AMBAS and the mode width constant.
REQ-029 Sub-module detector_borda_canal SHALL implement one channel (sync, debounce, edge, sticky, ovf), instantiated N times by generate; top adds irq only.

Verification
REQ-030 N=8, modo all 01, entrada[0] 0->1 held -> pulso[0]=1 for one cycle at cycle 2+4+1=7, sticky[0]=1, irq=1 at cycle 8.
REQ-031 modo[3:2]=11, entrada[1] high 20 cycles then low -> two pulses on pulso[1]; second event sets ovf[1]=1.
REQ-032 entrada[2] pulse 3 cycles wide, DEB_CYCLES=4 -> no pulso[2], sticky[2] stays 0; repeat with macro undefined -> pulso[2] at cycle 3.
REQ-033 clr[0]=1 in same cycle as new event on channel 0 -> sticky[0]=1, ovf[0]=0; clr alone -> sticky[0]=0, irq=0 one cycle later.
REQ-034 entrada all 1 during rst, release rst -> pulso=8'hFF exactly once at full latency; rst mid-debounce -> no pulse.
